// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 width codes, LSU state, bus command bundle.
// Pure declarations; no latency or backpressure of its own.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_cmd_t;

endpackage

// File: rtl/lsu_lane_format.sv
// Byte-lane steering: store byte enables/replication, load extraction/extension, alignment checks.
// Purely combinational (zero latency); no flow control.
module lsu_lane_format
  import riscv_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic        sext;
  logic [31:0] shifted;

  assign sext    = ~funct3[2];
  // Aligned halves have addr_lo[0]=0, so a byte-granular shift also selects the half lane.
  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    illegal    = write ? (funct3[2] || (funct3[1:0] == 2'b11))
                       : ((funct3[1:0] == 2'b11) || (funct3 == 3'b110));
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: be = 4'b0000;
    endcase
    // An illegal code is reported as a fault, never as misaligned.
    if (illegal) misaligned = 1'b0;
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit bridging the pipeline to a valid/ready word bus.
// Latency >= 3 cycles (IDLE->BUSY->RESP); pipeline stalled while the bus withholds bus_ready or until timeout.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_out,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned_out,
  output logic        fault_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [15:0] tmo_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        fault_q;

  logic        idle;
  logic        start;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        fmt_misaligned;
  logic        fmt_illegal;
  bus_cmd_t    cmd;

  assign idle = (state == IDLE);

  // While BUSY the formatter sees the captured request so load extraction is independent of req_*.
  lsu_lane_format u_fmt (
    .write      (idle ? req_write : bus_we),
    .funct3     (idle ? req_funct3 : funct3_q),
    .addr_lo    (idle ? req_addr[1:0] : addr_lo_q),
    .store_data (req_wdata),
    .rdata      (bus_rdata),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .load_data  (fmt_load),
    .misaligned (fmt_misaligned),
    .illegal    (fmt_illegal)
  );

  assign start          = idle && req_valid && !fmt_misaligned && !fmt_illegal;
  assign stall_out      = start || (state == BUSY);
  assign misaligned_out = idle && req_valid && fmt_misaligned;
  assign fault_out      = fault_q || (idle && req_valid && fmt_illegal);

  assign cmd = '{we: req_write, addr: {req_addr[31:2], 2'b00}, wdata: fmt_wdata, be: fmt_be};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      fault_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= cmd.we;
            bus_addr  <= cmd.addr;
            bus_wdata <= cmd.wdata;
            bus_be    <= cmd.be;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            tmo_cnt   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bus_ready) begin
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (!bus_we && !bus_err) ? fmt_load : 32'd0;
            fault_q   <= bus_err;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            fault_q   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          fault_q   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard queue of expected responses, checked by a monitor.
// Bus side is modelled inline with a programmable number of wait cycles.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall_out, rsp_valid, misaligned_out, fault_out;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_out(stall_out), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misaligned_out(misaligned_out), .fault_out(fault_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = completed access, 1 = misaligned reject, 2 = illegal funct3 reject
  typedef struct {
    int          kind;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (rsp_valid || misaligned_out || fault_out)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rsp_valid=%b misaligned=%b fault=%b with nothing expected",
                 rsp_valid, misaligned_out, fault_out);
      end else begin
        e = sb_q.pop_front();
        check("mon_rsp_valid", 32'(rsp_valid), 32'(e.kind == 0));
        check("mon_misaligned", 32'(misaligned_out), 32'(e.kind == 1));
        check("mon_fault", 32'(fault_out), 32'(e.fault));
        check("mon_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // waits < 0 means the bus never answers.
  task automatic access(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input logic err,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rsp,
                        input logic exp_fault);
    int stalls, reqs, exp_reqs;
    bit done, bad_cmd;
    sb_q.push_back('{kind: 0, rdata: exp_rsp, fault: exp_fault});
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    bus_rdata = rd; bus_err = err;
    @(negedge clk);
    stalls = stall_out ? 1 : 0;
    @(posedge clk); #1;
    bus_ready = (waits == 0);
    done = 0; reqs = 0; bad_cmd = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1;
      end else begin
        if (stall_out) stalls++;
        if (bus_req) reqs++;
        if (bus_we !== w || bus_addr !== exp_addr || bus_be !== exp_be || bus_wdata !== exp_wd)
          bad_cmd = 1;
        @(posedge clk); #1;
        bus_ready = (n + 1 == waits);
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    check({tag, "_resp_stall"}, 32'(stall_out), 32'd0);
    req_valid = 1'b0;
    bus_ready = 1'b0;
    exp_reqs = (waits >= 0) ? waits + 1 : 8;
    check({tag, "_bus_cmd_mismatch"}, 32'(bad_cmd), 32'd0);
    check({tag, "_bus_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_reqs + 1));
    @(posedge clk); #1;
  endtask

  task automatic reject(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input int kind);
    sb_q.push_back('{kind: kind, rdata: 32'd0, fault: (kind == 2)});
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = 32'h1234_5678;
    @(negedge clk);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_stays_idle"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    bus_ready = 0; bus_rdata = 0; bus_err = 0;
    #12;
    check("reset_bus_req", 32'(bus_req), 32'd0);
    check("reset_bus_we", 32'(bus_we), 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_bus_wdata", bus_wdata, 32'd0);
    check("reset_bus_be", 32'(bus_be), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_flags", {29'd0, stall_out, misaligned_out, fault_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //      tag     w  f3      addr          wdata         waits rdata         err exp_addr      be       exp_wdata     exp_rsp       fault
    access("sw",    1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0,        0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
    access("sb",    1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0,        0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0);
    access("sh",    1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 32'h0,        0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0);
    access("lb",    0, 3'b000, 32'h0000_0302, 32'h0,         4, 32'h12F0_3456, 0, 32'h0000_0300, 4'b0100, 32'h0,        32'hFFFF_FFF0, 0);
    access("lbu",   0, 3'b100, 32'h0000_0302, 32'h0,         4, 32'h12F0_3456, 0, 32'h0000_0300, 4'b0100, 32'h0,        32'h0000_00F0, 0);
    access("lhu",   0, 3'b101, 32'h0000_0302, 32'h0,         4, 32'h12F0_3456, 0, 32'h0000_0300, 4'b1100, 32'h0,        32'h0000_12F0, 0);
    access("lh",    0, 3'b001, 32'h0000_0300, 32'h0,         0, 32'h0000_8001, 0, 32'h0000_0300, 4'b0011, 32'h0,        32'hFFFF_8001, 0);
    access("lw",    0, 3'b010, 32'h0000_0100, 32'h0,         2, 32'hCAFE_F00D, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hCAFE_F00D, 0);

    reject("lw_mis", 0, 3'b010, 32'h0000_0101, 1);
    reject("lh_mis", 0, 3'b001, 32'h0000_0103, 1);
    reject("ld_ill", 0, 3'b011, 32'h0000_0100, 2);
    reject("st_ill", 1, 3'b100, 32'h0000_0100, 2);

    access("lw_tmo", 0, 3'b010, 32'h0000_0400, 32'h0,        -1, 32'h5555_5555, 0, 32'h0000_0400, 4'b1111, 32'h0,        32'h0,        1);
    access("lw_err", 0, 3'b010, 32'h0000_0500, 32'h0,         2, 32'h1111_1111, 1, 32'h0000_0500, 4'b1111, 32'h0,        32'h0,        1);

    // Reset asserted while the bus request is outstanding.
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h0000_0600; req_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    check("rst_busy_pre_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy_req_drop", 32'(bus_req), 32'd0);
    check("rst_busy_idle", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access("sw_post", 1, 3'b010, 32'h0000_0708, 32'h0BAD_F00D, 0, 32'h0,      0, 32'h0000_0708, 4'b1111, 32'h0BAD_F00D, 32'h0,        0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the MEM stage, between the EX/MEM pipeline register and a word-addressed data bus (data RAM plus MMIO).
- Replaces the single-cycle data-memory assumption with a valid/ready bus handshake.
- Handles byte, half and word alignment, byte enables, and load sign/zero extension.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without bus_ready before the access is aborted with a fault (range 1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  MEM stage holds a load/store this cycle
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  effective byte address (ALU result)
req_wdata  in  32  store data (rs2, forwarded)
stall_out  out  1  hold the pipeline (IF/ID/EX/MEM frozen)
rsp_valid  out  1  one-cycle pulse: access complete, rsp_rdata valid
rsp_rdata  out  32  load result after extension; 0 for stores and faults
misaligned_out  out  1  one-cycle pulse: misaligned access rejected
fault_out  out  1  one-cycle pulse: bus error, timeout or illegal funct3
bus_req  out  1  bus request, registered
bus_we  out  1  bus write enable
bus_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ready  in  1  bus accepts/completes the access this cycle
bus_rdata  in  32  read word, valid with bus_ready
bus_err  in  1  error qualifier, sampled only with bus_ready

Behaviour:
Reset
- Asynchronous reset: state = IDLE, timeout counter = 0.
- All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_be, rsp_valid, rsp_rdata, misaligned_out, fault_out.

State machine: IDLE, BUSY, RESP.
- IDLE, req_valid=0: nothing happens; stall_out=0.
- IDLE, req_valid=1, legal and aligned:
  - stall_out=1 combinationally.
  - Register bus_req=1, bus_we, bus_addr, bus_wdata, bus_be; next state BUSY.
- IDLE, req_valid=1, misaligned or illegal funct3:
  - No bus request, stall_out=0, rsp_rdata=0.
  - Same cycle (combinational): misaligned_out=1 if misaligned, else fault_out=1 for illegal funct3.
  - Stay in IDLE.
  - Misaligned means: half-word with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal load funct3: 011, 110, 111. Illegal store funct3: anything other than 000, 001, 010.
- BUSY:
  - stall_out=1. bus_req, bus_we, bus_addr, bus_wdata, bus_be held stable until bus_ready.
  - Counter increments every BUSY cycle.
  - bus_ready=1: drop bus_req next cycle, go to RESP. Register extended load data, or 0 for stores and errors. Register fault_out=bus_err.
  - Counter reaches TIMEOUT_CYCLES with no bus_ready: drop bus_req, go to RESP with fault_out=1 and rsp_rdata=0.
  - bus_ready and timeout in the same cycle: bus_ready wins.
- RESP:
  - stall_out=0, rsp_valid=1. fault_out held for this one cycle only.
  - The pipeline advances at the end of this cycle; next state IDLE.
  - req_valid in RESP belongs to the completed op and is ignored.
- Minimum latency: 3 cycles (IDLE→BUSY→RESP) when bus_ready arrives in the first BUSY cycle. Stall length is 2 cycles.
- Reset mid-BUSY: bus_req falls asynchronously and the transaction is abandoned. The bus must tolerate the withdrawn request.

Store formatting
- SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
- SW: be = 4'b1111; wdata unchanged.
- Loads drive the same be pattern with bus_we=0.

Load extraction
- LB/LBU: byte at lane addr[1:0]. LH/LHU: half at lane addr[1]. LW: full word.
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.

Decomposition:
- Shared package (existing riscv_pkg):
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101 (SB/SH/SW reuse 000/001/010).
  - lsu_state_t enum {IDLE, BUSY, RESP}.
- One combinational sub-module, lsu_lane_format:
  - Inputs: funct3, addr[1:0], store data, bus_rdata.
  - Outputs: bus_be, bus_wdata, extended rdata, misaligned, illegal.
- FSM, timeout counter and output registers stay in load_store_unit.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, bus_ready in first BUSY cycle → bus_addr=0x104, be=1111, wdata=0xDEADBEEF, stall_out high 2 cycles, rsp_valid in cycle 3.
- SB addr=0x203, wdata=0x000000A5 → be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
- LB addr=0x302 with bus_rdata=0x12F0_3456, ready after 4 wait cycles → rsp_rdata=0xFFFFFFF0, bus_req stable all 5 BUSY cycles. Repeat as LBU → 0x000000F0. Repeat as LHU addr=0x302 → 0x000012F0.
- LW addr=0x101 → misaligned_out pulse same cycle, bus_req stays 0, stall_out 0. LH addr=0x103 → same result.
- LW with bus_ready never asserted, TIMEOUT_CYCLES=8 → bus_req drops after 8 BUSY cycles, RESP with fault_out=1, rsp_rdata=0. Separately, bus_ready with bus_err=1 → fault_out=1 in RESP.
- Assert rst during BUSY → bus_req=0 and state=IDLE immediately (asynchronous). After release, a fresh SW completes normally.
